rr_mult_pipe: RTL and testbench
===============================

// Module: rr_mult_pipe
// PURPOSE
//  Parametrised, pipelined recursive-split unsigned multiplier; successor to fixed-size combinational rr blocks.
//  Splits A,B into high (WIDTH-SPLIT) and low (SPLIT) fields, forms HH/HL/LH/LL sub-products, recombines by shift-add.
//  Valid/ready streaming in/out with tag pass-through; optional approximate LL term for NSGA design-space sweeps.
// PARAMETERS
//  WIDTH      8  operand width, >=2
//  SPLIT      1  low-field width L, 1..WIDTH-1; high width H=WIDTH-SPLIT
//  APPROX_LL  0  0: LL=A_L*B_L exact; 1: LL forced to 0 (truncated)
//  TAG_W      4  width of sideband tag carried with each operation
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst_n      in   1          synchronous active-low reset
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          block accepts beat this cycle
//  in_a       in   WIDTH      multiplicand, unsigned
//  in_b       in   WIDTH      multiplier, unsigned
//  in_tag     in   TAG_W      sideband, returned unchanged with result
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  out_p      out  2*WIDTH    product
//  out_tag    out  TAG_W      tag of this product
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all stage valids 0; out_valid=0, out_p=0, out_tag=0; in_ready=1 from next cycle.
//  - Three stages S1 operand reg, S2 sub-products reg (HH H*H, HL H*L, LH L*H, LL L*L), S3 sum reg.
//  - S3 sum = (HH<<2L)+((HL+LH)<<L)+LL, computed in 2*WIDTH+1 bits, truncated to 2*WIDTH (never overflows).
//  - Stage k advances when empty or stage k+1 advances; S3 advances when !out_valid or out_ready.
//  - in_ready = S1 advance condition (combinational from out_ready; bubbles collapse).
//  - Transfer on in_valid&in_ready; result on out_valid&out_ready. Latency 3 cycles, throughput 1/cycle.
//  - out_p/out_tag hold stable while out_valid&!out_ready; strict in-order, no drop, no duplicate.
//  - Pipeline full + out_ready=0: in_ready=0; holds exactly 3 beats.
//  - Simultaneous accept and output with full pipe: all stages shift, in_ready=1.
//  - Reset mid-operation discards all in-flight beats; nothing emitted afterwards.
//  - Operands 0 or all-ones are not special-cased; 0 gives 0, max gives (2^W-1)^2.
// CONFIGURATION
//  RR_MULT_ERRSTAT_EN defined: extra exact product carried alongside each beat;
//   ports stat_clr(in,1), err_cnt(out,16), err_max(out,2*WIDTH) added.
//   On each output transfer with out_p!=exact: err_cnt+=1 saturating at 16'hFFFF;
//   err_max=max(err_max,exact-out_p). stat_clr=1 zeroes both (priority over update); reset zeroes both.
//   With APPROX_LL=0 both stay 0.
//  Not defined: no extra ports, no exact datapath, no counters.
// STRUCTURE
//  Package rr_mult_pkg: localparam helpers hi_w(WIDTH,SPLIT), prod_w(WIDTH); stage-valid typedef.
//  Sub-module nr_mult_core #(AW,BW): combinational unsigned AW x BW -> AW+BW product;
//   instantiated 4x in S2 (LL instance omitted when APPROX_LL=1) and, under macro, once for exact.
//  Handshake/stall logic and shift-add stay in rr_mult_pipe.
// TESTING
//  1 W=4,S=1: a=15,b=15,tag=3, out_ready=1 -> out_p=225, tag=3 exactly 3 cycles after accept.
//  2 W=4,S=1: back-to-back (2,3),(7,9),(0,13),(15,1) -> 6,63,0,15 on 4 consecutive cycles.
//  3 W=8,S=3: out_ready=0, push 5 beats -> in_ready low after 3 accepted; release -> 3 in order, then rest.
//  4 W=8,S=3: 200*123 -> 24600; 255*255 -> 65025; rst_n low one cycle with 2 in flight -> no output follows.
//  5 APPROX_LL=1,W=4,S=1, macro on: (1,1) -> out_p=0, err_cnt=1, err_max=1; (3,5) -> 14, err_cnt=2, err_max=1.
//  6 Macro on: pulse stat_clr same cycle as erroneous output -> err_cnt=0, err_max=0 next cycle.
//  Random soak (all params above): scoreboard vs a*b; stall/valid randomised; no loss or reorder.

Source files
------------

// File: rtl/rr_mult_pkg.sv
// Shared helpers and types for the pipelined recursive-split multiplier.
package rr_mult_pkg;

    function automatic int unsigned hi_w(input int unsigned width, input int unsigned split);
        return width - split;
    endfunction

    function automatic int unsigned prod_w(input int unsigned width);
        return 2 * width;
    endfunction

    typedef struct packed {
        logic s3;
        logic s2;
        logic s1;
    } stage_vld_t;

endpackage

// File: rtl/nr_mult_core.sv
// Combinational unsigned AW x BW multiplier producing a full-width product.
module nr_mult_core #(
    parameter int unsigned AW = 4,
    parameter int unsigned BW = 4
) (
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    output logic [AW+BW-1:0] p_o
);

    assign p_o = (AW+BW)'(a_i) * (AW+BW)'(b_i);

endmodule

// File: rtl/rr_mult_pipe.sv
// Three-stage recursive-split unsigned multiplier with valid/ready streaming and tag pass-through.
// Optional error statistics (approximate vs exact product) enabled by defining RR_MULT_ERRSTAT_EN.
module rr_mult_pipe
    import rr_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SPLIT     = 1,
    parameter int unsigned APPROX_LL = 0,
    parameter int unsigned TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
`ifdef RR_MULT_ERRSTAT_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        err_cnt,
    output logic [2*WIDTH-1:0] err_max
`endif
);

    localparam int unsigned HW = hi_w(WIDTH, SPLIT);
    localparam int unsigned LW = SPLIT;
    localparam int unsigned PW = prod_w(WIDTH);
    localparam int unsigned SW = PW + 1;

    stage_vld_t         vld_q, vld_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic [2*HW-1:0]    hh_q, hh_d, hh_c;
    logic [HW+LW-1:0]   hl_q, hl_d, hl_c;
    logic [LW+HW-1:0]   lh_q, lh_d, lh_c;
    logic [2*LW-1:0]    ll_q, ll_d, ll_c;
    logic [PW-1:0]      p_q, p_d;
    logic [SW-1:0]      sum_c;
    logic               adv1_c, adv2_c, adv3_c;

    nr_mult_core #(.AW(HW), .BW(HW)) u_hh (.a_i(a_q[WIDTH-1:LW]), .b_i(b_q[WIDTH-1:LW]), .p_o(hh_c));
    nr_mult_core #(.AW(HW), .BW(LW)) u_hl (.a_i(a_q[WIDTH-1:LW]), .b_i(b_q[LW-1:0]),    .p_o(hl_c));
    nr_mult_core #(.AW(LW), .BW(HW)) u_lh (.a_i(a_q[LW-1:0]),    .b_i(b_q[WIDTH-1:LW]), .p_o(lh_c));

    generate
        if (APPROX_LL != 0) begin : g_ll_trunc
            assign ll_c = '0;
        end else begin : g_ll_exact
            nr_mult_core #(.AW(LW), .BW(LW)) u_ll (.a_i(a_q[LW-1:0]), .b_i(b_q[LW-1:0]), .p_o(ll_c));
        end
    endgenerate

    // One guard bit covers the carry out of the shift-add before truncation.
    assign sum_c = (SW'(hh_q) << (2 * LW))
                 + ((SW'(hl_q) + SW'(lh_q)) << LW)
                 + SW'(ll_q);

    // Stall chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        tag1_d = tag1_q;
        hh_d   = hh_q;
        hl_d   = hl_q;
        lh_d   = lh_q;
        ll_d   = ll_q;
        tag2_d = tag2_q;
        p_d    = p_q;
        tag3_d = tag3_q;

        adv3_c = !vld_q.s3 || out_ready;
        adv2_c = !vld_q.s2 || adv3_c;
        adv1_c = !vld_q.s1 || adv2_c;

        if (adv1_c) begin
            vld_d.s1 = in_valid;
            if (in_valid) begin
                a_d    = in_a;
                b_d    = in_b;
                tag1_d = in_tag;
            end
        end
        if (adv2_c) begin
            vld_d.s2 = vld_q.s1;
            if (vld_q.s1) begin
                hh_d   = hh_c;
                hl_d   = hl_c;
                lh_d   = lh_c;
                ll_d   = ll_c;
                tag2_d = tag1_q;
            end
        end
        if (adv3_c) begin
            vld_d.s3 = vld_q.s2;
            if (vld_q.s2) begin
                p_d    = PW'(sum_c);
                tag3_d = tag2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag1_q <= '0;
            hh_q   <= '0;
            hl_q   <= '0;
            lh_q   <= '0;
            ll_q   <= '0;
            tag2_q <= '0;
            p_q    <= '0;
            tag3_q <= '0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            tag1_q <= tag1_d;
            hh_q   <= hh_d;
            hl_q   <= hl_d;
            lh_q   <= lh_d;
            ll_q   <= ll_d;
            tag2_q <= tag2_d;
            p_q    <= p_d;
            tag3_q <= tag3_d;
        end
    end

    assign in_ready  = adv1_c;
    assign out_valid = vld_q.s3;
    assign out_p     = p_q;
    assign out_tag   = tag3_q;

`ifdef RR_MULT_ERRSTAT_EN
    // Exact product rides alongside the beat so the output can be scored on transfer.
    logic [PW-1:0] ex_c, ex2_q, ex2_d, ex3_q, ex3_d, diff_c;
    logic [PW-1:0] err_max_q, err_max_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    nr_mult_core #(.AW(WIDTH), .BW(WIDTH)) u_exact (.a_i(a_q), .b_i(b_q), .p_o(ex_c));

    assign diff_c = ex3_q - p_q;

    always_comb begin
        ex2_d     = ex2_q;
        ex3_d     = ex3_q;
        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (adv2_c && vld_q.s1) ex2_d = ex_c;
        if (adv3_c && vld_q.s2) ex3_d = ex2_q;
        if (stat_clr) begin
            err_cnt_d = '0;
            err_max_d = '0;
        end else if (vld_q.s3 && out_ready && (p_q != ex3_q)) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (diff_c > err_max_q)    err_max_d = diff_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex2_q     <= '0;
            ex3_q     <= '0;
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            ex2_q     <= ex2_d;
            ex3_q     <= ex3_d;
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_rr_mult_pipe.sv
// Directed bench for rr_mult_pipe: exact and approximate W=4/S=1 pair plus an exact W=8/S=3 instance.
module tb_rr_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    logic       v4, ordy4;
    logic [3:0] a4, b4, t4;
    logic       rdy4, ov4, rdya, ova;
    logic [7:0] p4, pa;
    logic [3:0] tag4, taga;

    logic        v8, ordy8;
    logic [7:0]  a8, b8;
    logic [3:0]  t8;
    logic        rdy8, ov8;
    logic [15:0] p8;
    logic [3:0]  tag8;

`ifdef RR_MULT_ERRSTAT_EN
    logic        stat_clr;
    logic [15:0] ec4, eca, ec8;
    logic [7:0]  em4, ema;
    logic [15:0] em8;
`endif

    rr_mult_pipe #(.WIDTH(4), .SPLIT(1), .APPROX_LL(0), .TAG_W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4),
        .in_tag(t4), .out_valid(ov4), .out_ready(ordy4), .out_p(p4), .out_tag(tag4)
`ifdef RR_MULT_ERRSTAT_EN
        , .stat_clr(stat_clr), .err_cnt(ec4), .err_max(em4)
`endif
    );

    rr_mult_pipe #(.WIDTH(4), .SPLIT(1), .APPROX_LL(1), .TAG_W(4)) u_apx (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdya), .in_a(a4), .in_b(b4),
        .in_tag(t4), .out_valid(ova), .out_ready(ordy4), .out_p(pa), .out_tag(taga)
`ifdef RR_MULT_ERRSTAT_EN
        , .stat_clr(stat_clr), .err_cnt(eca), .err_max(ema)
`endif
    );

    rr_mult_pipe #(.WIDTH(8), .SPLIT(3), .APPROX_LL(0), .TAG_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .in_tag(t8), .out_valid(ov8), .out_ready(ordy8), .out_p(p8), .out_tag(tag8)
`ifdef RR_MULT_ERRSTAT_EN
        , .stat_clr(stat_clr), .err_cnt(ec8), .err_max(em8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Single W=4 beat; returns at the negedge where the result is first visible.
    task automatic w4_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] tag,
                           input logic [7:0] e_exact, input logic [7:0] e_apx);
        @(negedge clk);
        v4 = 1'b1; a4 = a; b4 = b; t4 = tag; ordy4 = 1'b1;
        #1 chk("w4_in_ready", 32'(rdy4), 1);
        @(negedge clk);
        v4 = 1'b0;
        chk("w4_lat1", 32'(ov4), 0);
        @(negedge clk);
        chk("w4_lat2", 32'(ov4), 0);
        @(negedge clk);
        chk("w4_valid", 32'(ov4), 1);
        chk("w4_p", 32'(p4), 32'(e_exact));
        chk("w4_tag", 32'(tag4), 32'(tag));
        chk("apx_valid", 32'(ova), 1);
        chk("apx_p", 32'(pa), 32'(e_apx));
        chk("apx_tag", 32'(taga), 32'(tag));
    endtask

    typedef struct {
        logic [15:0] p;
        logic [3:0]  t;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;

    logic [7:0]  s2_a [4] = '{8'd2, 8'd7, 8'd0, 8'd15};
    logic [7:0]  s2_b [4] = '{8'd3, 8'd9, 8'd13, 8'd1};
    logic [7:0]  s2_e [4] = '{8'd6, 8'd63, 8'd0, 8'd15};
    logic [7:0]  s2_x [4] = '{8'd6, 8'd62, 8'd0, 8'd14};
    logic [7:0]  s3_a [5] = '{8'd200, 8'd255, 8'd0, 8'd13, 8'd1};
    logic [7:0]  s3_b [5] = '{8'd123, 8'd255, 8'd77, 8'd17, 8'd255};
    logic [15:0] s3_e [5] = '{16'd24600, 16'd65025, 16'd0, 16'd221, 16'd255};

    initial begin
        int   idx;
        int   ri;
        logic stalled;
        logic [15:0] hold_p;
        logic [3:0]  hold_t;

        rst_n = 1'b0;
        v4 = 1'b0; ordy4 = 1'b1; a4 = '0; b4 = '0; t4 = '0;
        v8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; t8 = '0;
`ifdef RR_MULT_ERRSTAT_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ov4", 32'(ov4), 0);
        chk("rst_p4", 32'(p4), 0);
        chk("rst_tag4", 32'(tag4), 0);
        chk("rst_ov8", 32'(ov8), 0);
        chk("rst_p8", 32'(p8), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy4", 32'(rdy4), 1);
        chk("rst_rdy8", 32'(rdy8), 1);

        // Truncated LL term: (1,1) and (3,5).
        w4_beat(4'd1, 4'd1, 4'd2, 8'd1, 8'd0);
        @(negedge clk);
`ifdef RR_MULT_ERRSTAT_EN
        chk("apx_errcnt1", 32'(eca), 1);
        chk("apx_errmax1", 32'(ema), 1);
        chk("w4_errcnt1", 32'(ec4), 0);
`endif
        w4_beat(4'd3, 4'd5, 4'd5, 8'd15, 8'd14);
        @(negedge clk);
`ifdef RR_MULT_ERRSTAT_EN
        chk("apx_errcnt2", 32'(eca), 2);
        chk("apx_errmax2", 32'(ema), 1);
`endif

        // Clear coincides with an erroneous output transfer.
        w4_beat(4'd1, 4'd1, 4'd4, 8'd1, 8'd0);
`ifdef RR_MULT_ERRSTAT_EN
        stat_clr = 1'b1;
`endif
        @(negedge clk);
`ifdef RR_MULT_ERRSTAT_EN
        stat_clr = 1'b0;
        chk("apx_clr_cnt", 32'(eca), 0);
        chk("apx_clr_max", 32'(ema), 0);
`endif

        w4_beat(4'd15, 4'd15, 4'd3, 8'd225, 8'd224);

        // Back-to-back stream: results on four consecutive cycles.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                chk("bb_valid", 32'(ov4), 1);
                chk("bb_p", 32'(p4), 32'(s2_e[k-3]));
                chk("bb_tag", 32'(tag4), 32'(k + 5));
                chk("bb_apx_p", 32'(pa), 32'(s2_x[k-3]));
            end else begin
                chk("bb_idle", 32'(ov4), 0);
            end
            if (k < 4) begin
                v4 = 1'b1; a4 = s2_a[k][3:0]; b4 = s2_b[k][3:0]; t4 = 4'(k + 8);
            end else begin
                v4 = 1'b0;
            end
        end
`ifdef RR_MULT_ERRSTAT_EN
        chk("w4_errcnt_end", 32'(ec4), 0);
        chk("w4_errmax_end", 32'(em4), 0);
        chk("apx_errcnt_end", 32'(eca), 3);
        chk("apx_errmax_end", 32'(ema), 1);
`endif

        // Backpressure: pipe holds three beats, output held stable, then drains in order.
        idx = 0;
        ri  = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            ordy8 = (cyc >= 5);
            if (cyc == 3 || cyc == 4) begin
                chk("bp_hold_v", 32'(ov8), 1);
                chk("bp_hold_p", 32'(p8), 24600);
                chk("bp_hold_tag", 32'(tag8), 1);
            end
            if (ov8 && ordy8) begin
                if (ri < 5) begin
                    chk("bp_p", 32'(p8), 32'(s3_e[ri]));
                    chk("bp_tag", 32'(tag8), 32'(ri + 1));
                end else begin
                    chk("bp_extra", 32'(ov8), 0);
                end
                ri++;
            end
            if (idx < 5) begin
                v8 = 1'b1; a8 = s3_a[idx]; b8 = s3_b[idx]; t8 = 4'(idx + 1);
            end else begin
                v8 = 1'b0;
            end
            #1;
            if (cyc < 3)                chk("bp_rdy_fill", 32'(rdy8), 1);
            if (cyc == 3 || cyc == 4)   chk("bp_rdy_full", 32'(rdy8), 0);
            if (cyc == 5)               chk("bp_rdy_shift", 32'(rdy8), 1);
            if (v8 && rdy8) idx++;
        end
        chk("bp_count", 32'(ri), 5);

        // Reset with two beats in flight discards them.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'd100; b8 = 8'd3; t8 = 4'd6; ordy8 = 1'b1;
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; t8 = 4'd7;
        @(negedge clk);
        v8 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_flush", 32'(ov8), 0);
        end

        // Randomised soak against a scoreboard.
        stalled = 1'b0;
        hold_p  = '0;
        hold_t  = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (stalled) begin
                chk("sk_hold_v", 32'(ov8), 1);
                chk("sk_hold_p", 32'(p8), 32'(hold_p));
                chk("sk_hold_tag", 32'(tag8), 32'(hold_t));
            end
            ordy8 = ($urandom_range(0, 3) != 0);
            v8    = ($urandom_range(0, 2) != 0);
            a8    = 8'($urandom_range(0, 255));
            b8    = 8'($urandom_range(0, 255));
            t8    = 4'(i);
            #1;
            if (ov8 && ordy8) begin
                if (sb_q.size() == 0) begin
                    chk("sk_extra", 32'(ov8), 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sk_p", 32'(p8), 32'(sb_e.p));
                    chk("sk_tag", 32'(tag8), 32'(sb_e.t));
                end
            end
            stalled = ov8 && !ordy8;
            hold_p  = p8;
            hold_t  = tag8;
            if (v8 && rdy8) begin
                sb_e.p = 16'(a8) * 16'(b8);
                sb_e.t = t8;
                sb_q.push_back(sb_e);
            end
        end
        @(negedge clk);
        v8    = 1'b0;
        ordy8 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (ov8) begin
                if (sb_q.size() == 0) begin
                    chk("sk_drain_extra", 32'(ov8), 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sk_drain_p", 32'(p8), 32'(sb_e.p));
                    chk("sk_drain_tag", 32'(tag8), 32'(sb_e.t));
                end
            end
            @(negedge clk);
        end
        chk("sk_left", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
